// File: rtl/mix_columns_engine.sv
// -----------------------------------------------------------------------------
// mix_columns_engine
//
// Applies AES MixColumns (or InvMixColumns) to a 128-bit state. The state is
// captured into an internal register and transformed in place, LANES columns
// per cycle. The result is then held until the consumer takes it.
//
// Parameters
//   LANES   columns processed per cycle (1, 2 or 4)
//   INV_EN  1 = inverse transform available, 0 = in_inv ignored (forward only)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input state offered
//   in_ready   engine idle and able to accept a state
//   in_state   AES state, column c = [127-32c -: 32], row r = [127-32c-8r -: 8]
//   in_inv     0 = MixColumns, 1 = InvMixColumns (sampled with in_state)
//   out_valid  result held valid
//   out_ready  consumer accepts the result
//   out_state  transformed state, same layout as in_state
//   busy       operation in progress or result waiting
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an input transfer
// BUSY  | transforming one column group per cycle
// DONE  | result presented, waiting for out_ready
// -----------------------------------------------------------------------------
module mix_columns_engine #(
    parameter int LANES  = 1,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("mix_columns_engine: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int GROUPS = 4 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] grp;
    logic [127:0]  st_q;
    logic [127:0]  st_nxt;
    logic          inv_q;
    logic          last_grp;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r uses coefficient c0 on byte r, c1 on r+1, c2 on r+2, c3 on r+3
    // (indices mod 4); both matrices are circulant so this covers all rows.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  b  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            b[r]  = col[31-8*r -: 8];
            x2[r] = xtime(b[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            if (inv) begin
                res[31-8*r -: 8] = (x8[r]         ^ x4[r]         ^ x2[r])           // 0e
                                 ^ (x8[(r+1)%4]   ^ x2[(r+1)%4]   ^ b[(r+1)%4])      // 0b
                                 ^ (x8[(r+2)%4]   ^ x4[(r+2)%4]   ^ b[(r+2)%4])      // 0d
                                 ^ (x8[(r+3)%4]   ^ b[(r+3)%4]);                     // 09
            end else begin
                res[31-8*r -: 8] = x2[r]
                                 ^ (x2[(r+1)%4] ^ b[(r+1)%4])
                                 ^ b[(r+2)%4]
                                 ^ b[(r+3)%4];
            end
        end
        return res;
    endfunction

    assign last_grp = (grp == LAST_GRP);

    // In-place update of the current column group.
    always_comb begin
        st_nxt = st_q;
        for (int l = 0; l < LANES; l++) begin
            st_nxt[127 - 32*(int'(grp)*LANES + l) -: 32] =
                mix_col(st_q[127 - 32*(int'(grp)*LANES + l) -: 32], inv_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_grp)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            grp   <= '0;
            inv_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            st_q  <= in_state;
            inv_q <= (INV_EN != 0) ? in_inv : 1'b0;
            grp   <= '0;
        end else if (state == BUSY) begin
            st_q <= st_nxt;
            grp  <= last_grp ? '0 : grp + CW'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);
    assign out_state = st_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: four instances (LANES 1/2/4 with inverse,
// LANES 1 forward-only), directed vectors, backpressure, reset abort and
// random states against a matrix-level GF(2^8) reference model.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_state  [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_state [4];
    logic         busy      [4];

    logic [127:0] exp_q [4][$];
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [7:0] MF [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                         '{8'h01, 8'h02, 8'h03, 8'h01},
                                         '{8'h01, 8'h01, 8'h02, 8'h03},
                                         '{8'h03, 8'h01, 8'h01, 8'h02}};
    localparam logic [7:0] MI [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                         '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                         '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                         '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L  = (g == 1) ? 2 : (g == 2) ? 4 : 1;
        localparam int IE = (g == 3) ? 0 : 1;
        mix_columns_engine #(.LANES(L), .INV_EN(IE)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );

        always @(negedge clk) begin
            if (rst_n && out_valid[g] && out_ready[g]) begin
                if (exp_q[g].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output dut%0d: got %h expected none", g, out_state[g]);
                end else begin
                    chk($sformatf("result_dut%0d", g), out_state[g], exp_q[g].pop_front());
                end
            end
        end
    end

    function automatic int lanes_of(input int i);
        return (i == 1) ? 2 : (i == 2) ? 4 : 1;
    endfunction

    // Reference: shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(inv ? MI[r][k] : MF[r][k], s[127-32*c-8*k -: 8]);
                o[127-32*c-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called right after the transfer edge (+1). Optionally keeps in_valid
    // high with junk while busy, then measures cycles until out_valid.
    task automatic wait_result(input int i, input bit junk, input logic inv);
        int  n = 0;
        if (junk) begin
            in_valid[i] = 1'b1;
            in_state[i] = rand128();
            in_inv[i]   = ~inv;
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid[i]) break;
        end
        in_valid[i] = 1'b0;
        chk($sformatf("latency_dut%0d", i), 128'(n), 128'(4 / lanes_of(i)));
    endtask

    task automatic send(input int i, input logic [127:0] s, input logic inv,
                        input logic [127:0] exp, input bit junk);
        int k = 0;
        while (!in_ready[i] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("in_ready_before_send_dut%0d", i), 128'(in_ready[i]), 128'(1));
        in_valid[i] = 1'b1;
        in_state[i] = s;
        in_inv[i]   = inv;
        exp_q[i].push_back(exp);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        wait_result(i, junk, inv);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x, y, e, idv;
        logic         m;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_state[i]  = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b1;
        end
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_out_valid_dut%0d", i), 128'(out_valid[i]), 128'(0));
            chk($sformatf("rst_busy_dut%0d", i),      128'(busy[i]),      128'(0));
            chk($sformatf("rst_out_state_dut%0d", i), out_state[i],       128'(0));
        end
        #20 rst_n = 1'b1;                   // t=22, between edges
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rst_in_ready_dut%0d", i), 128'(in_ready[i]), 128'(1));

        // Known-answer vectors
        send(0, {32'hd4bf5d30, {3{32'hdb135345}}}, 1'b0,
                {32'h046681e5, {3{32'h8e4da1bc}}}, 1'b0);
        send(2, {4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}}, 1'b0);
        idv = {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101};
        send(1, idv, 1'b0, idv, 1'b0);
        send(1, idv, 1'b1, idv, 1'b0);
        send(3, {4{32'hdb135345}}, 1'b1, {4{32'h8e4da1bc}}, 1'b0);

        // Backpressure on dut0
        x = rand128();
        e = mix_ref(x, 1'b0);
        out_ready[0] = 1'b0;
        send(0, x, 1'b0, e, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("bp_out_state", out_state[0], e);
            chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
            chk("bp_in_ready",  128'(in_ready[0]),  128'(0));
            in_valid[0] = k[0];
            in_state[0] = rand128();
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  128'(in_ready[0]),  128'(1));
        chk("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("bp_no_ghost_busy", 128'(busy[0]), 128'(0));
        end

        // Reset during BUSY, then transfer on the first edge after release
        in_valid[0] = 1'b1;
        in_state[0] = rand128();
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(busy[0]), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid[0]), 128'(0));
        chk("abort_out_state", out_state[0], 128'(0));
        chk("abort_busy",      128'(busy[0]), 128'(0));
        in_valid[0] = 1'b1;
        in_state[0] = {4{32'hf20a225c}};
        in_inv[0]   = 1'b0;
        exp_q[0].push_back({4{32'h9fdc589d}});
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_result(0, 1'b0, 1'b0);

        // Random states, both modes, with junk on the input while busy
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 6; n++) begin
                x = rand128();
                m = 1'($urandom_range(0, 1));
                send(i, x, m, mix_ref(x, m && (i != 3)), 1'b1);
            end
        end

        // Round trip through the DUT: forward then inverse returns the original
        for (int i = 0; i < 3; i++) begin
            x = rand128();
            y = mix_ref(x, 1'b0);
            send(i, x, 1'b0, y, 1'b1);
            send(i, y, 1'b1, x, 1'b1);
        end

        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("queue_drained_dut%0d", i), 128'(exp_q[i].size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 Parameter LANES, default 1, meaning columns processed per cycle; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Parameter INV_EN, default 1, meaning inverse MixColumns support present; when 0, the mode input SHALL be ignored and forward SHALL always be used.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input state offered.
REQ-006 in_ready  output  1  engine can accept a state.
REQ-007 in_state  input  128  AES state; column c = bits [127-32c -: 32]; row r of column c = bits [127-32c-8r -: 8].
REQ-008 in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with in_state.
REQ-009 out_valid  output  1  result state held valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_state  output  128  transformed state, same byte layout as in_state.
REQ-012 busy  output  1  high in BUSY or DONE.

Function
REQ-013 Input handshake: transfer occurs on a rising edge with in_valid && in_ready; in_state and in_inv are captured into internal registers.
REQ-014 FSM states: IDLE, BUSY, DONE; IDLE->BUSY on input transfer; BUSY->DONE after the last column group is written; DONE->IDLE on out_valid && out_ready.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 In BUSY, each cycle processes LANES consecutive columns, starting at column 0; group counter width = clog2(4/LANES), min 1 bit.
REQ-017 Latency: out_valid asserts exactly 4/LANES cycles after the input transfer edge (LANES=1: 4; LANES=2: 2; LANES=4: 1).
REQ-018 Forward output byte r of column c = XOR over k of GF_mul(M[r][k], s[k][c]); M rows {02,03,01,01}, {01,02,03,01}, {01,01,02,03}, {03,01,01,02}.
REQ-019 Inverse uses rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
REQ-020 GF_mul is GF(2^8) multiply modulo x^8+x^4+x^3+x+1 (0x11B), all eight coefficient bits honoured; xtime(b) = (b<<1)[7:0] XOR (b[7] ? 0x1B : 0x00).
REQ-021 Column results are written in place into the state register; out_state is driven from that register and is stable throughout DONE.
REQ-022 Backpressure: while out_valid && !out_ready, out_state and out_valid SHALL hold unchanged for any number of cycles.
REQ-023 No new input is accepted in the cycle the output is consumed; in_ready rises the cycle after DONE->IDLE (throughput one state per 4/LANES+2 cycles with out_ready held high).
REQ-024 in_inv is used for the whole operation; changes to in_inv or in_state after capture SHALL not affect the result.
REQ-025 in_valid asserted outside IDLE SHALL be ignored; no state SHALL be lost or duplicated.

Reset
REQ-026 On rst_n low, immediately and asynchronously: FSM = IDLE, counter = 0, state register = 0, in_ready = 1 (visible once rst_n is released), out_valid = 0, busy = 0, out_state = 0.
REQ-027 Reset during BUSY or DONE aborts the operation; no partial result SHALL be presented after release.
REQ-028 First input transfer is possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 Forward, LANES=1: column 0 = d4 bf 5d 30, other columns db 13 53 45 -> out column 0 = 04 66 81 e5, others 8e 4d a1 bc; out_valid exactly 4 cycles after transfer.
REQ-030 Inverse, LANES=4, INV_EN=1: all columns 8e 4d a1 bc -> all columns db 13 53 45; out_valid 1 cycle after transfer.
REQ-031 Identity columns c6 c6 c6 c6 and 01 01 01 01, forward and inverse, LANES=2 -> unchanged output; latency 2.
REQ-032 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_state constant, in_ready = 0, and in_valid pulses ignored; then out_ready = 1 -> one transfer, in_ready = 1 on the next cycle.
REQ-033 Reset mid-BUSY (LANES=1, after 2 cycles) -> out_valid = 0 and out_state = 0 asynchronously; the next transfer of f2 0a 22 5c per column -> 9f dc 58 9d per column.
REQ-034 Random 128-bit states, both modes, all LANES -> match the reference model; forward-then-inverse round trip returns the original state.
